disp_scan_ctrl: RTL and testbench

Scan controller and display arbiter for the 4-digit multiplexed seven-segment display. It generates the digit-scan timing with an anti-ghosting blanking interval at the start of each digit slot. It latches the frequency/current setting once per frame so the display never changes mid-frame. It arbitrates the display between normal setting readout and a requester that flashes a 4-digit message for a fixed number of frames. It sits between the setting registers (`bf`, `bc`, `opcion`) and the board pins (`an`, `sseg`).

---
 rtl/disp_pkg.sv | 14 +
 rtl/hex_to_sseg.sv | 31 +++
 rtl/disp_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encoding and display constants for disp_scan_ctrl
package disp_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_MSG    = 1'b1
    } disp_state_t;

    localparam logic [3:0] CODE_F   = 4'hF;
    localparam logic [3:0] CODE_C   = 4'hC;
    localparam logic [7:0] SSEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_sseg (
    input  logic [3:0] code,
    output logic [7:0] sseg
);

    // Bit order {dp,g,f,e,d,c,b,a}, active-low; dp is kept dark.
    always_comb begin
        sseg = 8'hFF;
        case (code)
            4'h0: sseg = 8'hC0;
            4'h1: sseg = 8'hF9;
            4'h2: sseg = 8'hA4;
            4'h3: sseg = 8'hB0;
            4'h4: sseg = 8'h99;
            4'h5: sseg = 8'h92;
            4'h6: sseg = 8'h82;
            4'h7: sseg = 8'hF8;
            4'h8: sseg = 8'h80;
            4'h9: sseg = 8'h90;
            4'hA: sseg = 8'h88;
            4'hB: sseg = 8'h83;
            4'hC: sseg = 8'hC6;
            4'hD: sseg = 8'hA1;
            4'hE: sseg = 8'h86;
            4'hF: sseg = 8'h8E;
            default: sseg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit seven-segment scan controller with message arbiter
// Message arbitration is built only when DISP_MSG_EN is defined.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE   = 25000,
    parameter int BLANK_CYC  = 64,
    parameter int MSG_FRAMES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opcion,
    input  logic [3:0]  bf,
    input  logic [3:0]  bc,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    output logic        msg_ack,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = $clog2(MSG_FRAMES + 1);

    logic [PW-1:0] pre;
    logic [1:0]    dig;
    logic          frame_start;

    assign frame_start = (pre == '0) && (dig == 2'd0);
    assign frame_tick  = frame_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            dig <= 2'd0;
        end else if (pre == PW'(PRESCALE - 1)) begin
            pre <= '0;
            dig <= dig + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Settings are frozen for a whole frame so a digit never changes mid-scan.
    logic       snap_op;
    logic [3:0] snap_bf;
    logic [3:0] snap_bc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_op <= 1'b0;
            snap_bf <= 4'd0;
            snap_bc <= 4'd0;
        end else if (frame_start) begin
            snap_op <= opcion;
            snap_bf <= bf;
            snap_bc <= bc;
        end
    end

    logic        in_msg;
    logic [15:0] msg_buf;

`ifdef DISP_MSG_EN
    disp_state_t   state;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_NORMAL;
            fcnt    <= '0;
            msg_buf <= 16'h0000;
            msg_ack <= 1'b0;
        end else begin
            msg_ack <= 1'b0;
            if (frame_start) begin
                case (state)
                    ST_NORMAL: begin
                        if (msg_req) begin
                            msg_buf <= msg_data;
                            msg_ack <= 1'b1;
                            fcnt    <= '0;
                            state   <= ST_MSG;
                        end
                    end
                    ST_MSG: begin
                        fcnt <= fcnt + FW'(1);
                        if (fcnt == FW'(MSG_FRAMES - 1)) begin
                            state <= ST_NORMAL;
                        end
                    end
                    default: state <= ST_NORMAL;
                endcase
            end
        end
    end

    assign in_msg = (state == ST_MSG);
`else
    logic unused_msg_inputs;

    assign unused_msg_inputs = ^{msg_req, msg_data};
    assign in_msg  = 1'b0;
    assign msg_buf = 16'h0000;
    assign msg_ack = 1'b0;
`endif

    logic [3:0] value;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] code;
    logic       blank;
    logic [7:0] seg;

    assign value = snap_op ? snap_bc : snap_bf;
    assign ones  = (value >= 4'd10) ? (value - 4'd10) : value;
    assign tens  = {3'b000, (value >= 4'd10)};

    always_comb begin
        code  = 4'h0;
        blank = 1'b0;
        if (in_msg) begin
            code = msg_buf[{dig, 2'b00} +: 4];
        end else begin
            case (dig)
                2'd0: code = ones;
                2'd1: code = tens;
                2'd2: blank = 1'b1;
                default: code = snap_op ? CODE_C : CODE_F;
            endcase
        end
    end

    hex_to_sseg u_dec (
        .code (code),
        .sseg (seg)
    );

    // Pins lag the counters by one cycle, so fresh content lands inside the blanking window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an   <= AN_OFF;
            sseg <= SSEG_OFF;
        end else if ((pre < PW'(BLANK_CYC)) || blank) begin
            an   <= AN_OFF;
            sseg <= SSEG_OFF;
        end else begin
            an   <= ~(4'b0001 << dig);
            sseg <= seg;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard testbench for disp_scan_ctrl
module tb_disp_scan_ctrl;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int MSGF     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        opcion = 1'b0;
    logic [3:0]  bf = 4'd0;
    logic [3:0]  bc = 4'd0;
    logic        msg_req = 1'b0;
    logic [15:0] msg_data = 16'h0000;
    logic        msg_ack;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] exp_q[$];

    disp_scan_ctrl #(
        .PRESCALE   (PRESCALE),
        .BLANK_CYC  (BLANK),
        .MSG_FRAMES (MSGF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcion     (opcion),
        .bf         (bf),
        .bc         (bc),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_ack    (msg_ack),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Expected {msg_ack, an, sseg} per cycle for one frame; s = 8'hFF marks a blank digit.
    task automatic push_frame(input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0,
                              input logic ack0);
        logic [7:0] s[4];
        logic [3:0] a;
        logic [7:0] g;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < PRESCALE; p++) begin
                if (p < BLANK || s[d] == 8'hFF) begin
                    a = 4'hF;
                    g = 8'hFF;
                end else begin
                    a = 4'(~(4'b0001 << d));
                    g = s[d];
                end
                exp_q.push_back({(d == 0 && p == 0) ? ack0 : 1'b0, a, g});
            end
        end
    endtask

    task automatic wait_tick(output bit ok);
        for (int i = 0; i < 64 && frame_tick !== 1'b1; i++) @(negedge clk);
        ok = (frame_tick === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        opcion = 1'b0;
        bf = 4'd7;
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an: got %h want f", an); end
        vectors++;
        if (sseg !== 8'hFF) begin miscompares++; $display("FAIL reset_sseg: got %h want ff", sseg); end
        vectors++;
        if (msg_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", msg_ack); end
        vectors++;
        if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL reset_tick: got %b want 1", frame_tick); end
        rst_n = 1'b1;
    endtask

    task automatic test_freq;
        bit ok;
        push_frame(8'h8E, 8'hFF, 8'hC0, 8'hF8, 1'b0);
        push_frame(8'h8E, 8'hFF, 8'hC0, 8'hF8, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL freq_frame c=%0d: got %h want %h", c, o, e); end
        end
        wait_tick(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL freq_tick_period: got 0 want 1"); end
    endtask

    task automatic test_current;
        bit ok;
        wait_tick(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cur_tick: got 0 want 1"); end
        opcion = 1'b1;
        bc = 4'd12;
        push_frame(8'hC6, 8'hFF, 8'hF9, 8'hA4, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            if (c == 16) bc = 4'd3;
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL cur12_frame c=%0d: got %h want %h", c, o, e); end
        end
        push_frame(8'hC6, 8'hFF, 8'hC0, 8'hB0, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL cur3_frame c=%0d: got %h want %h", c, o, e); end
        end
    endtask

`ifdef DISP_MSG_EN
    task automatic test_msg;
        bit ok;
        wait_tick(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL msg_tick: got 0 want 1"); end
        msg_data = 16'h1234;
        msg_req = 1'b1;
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b1);
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
        push_frame(8'hC6, 8'hFF, 8'hC0, 8'hB0, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL msg_frame c=%0d: got %h want %h", c, o, e); end
            if (msg_ack === 1'b1) msg_req = 1'b0;
        end
        msg_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int first, second;
        first = -1;
        second = -1;
        wait_tick(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_tick: got 0 want 1"); end
        msg_data = 16'hABCD;
        msg_req = 1'b1;
        for (int c = 1; c <= 200 && second < 0; c++) begin
            @(negedge clk);
            if (msg_ack === 1'b1) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        msg_req = 1'b0;
        vectors++;
        if (first != 1) begin miscompares++; $display("FAIL b2b_first_ack: got %0d want 1", first); end
        vectors++;
        if (second - first != 96) begin
            miscompares++;
            $display("FAIL b2b_ack_spacing: got %0d want 96", second - first);
        end
    endtask
`else
    task automatic test_no_msg;
        bit ok;
        wait_tick(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL nomsg_tick: got 0 want 1"); end
        msg_data = 16'h1234;
        msg_req = 1'b1;
        push_frame(8'hC6, 8'hFF, 8'hC0, 8'hB0, 1'b0);
        push_frame(8'hC6, 8'hFF, 8'hC0, 8'hB0, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL nomsg_frame c=%0d: got %h want %h", c, o, e); end
        end
        msg_req = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL midrst_an: got %h want f", an); end
        vectors++;
        if (sseg !== 8'hFF) begin miscompares++; $display("FAIL midrst_sseg: got %h want ff", sseg); end
        vectors++;
        if (msg_ack !== 1'b0) begin miscompares++; $display("FAIL midrst_ack: got %b want 0", msg_ack); end
        vectors++;
        if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL midrst_tick: got %b want 1", frame_tick); end
        rst_n = 1'b1;
        push_frame(8'hC6, 8'hFF, 8'hC0, 8'hB0, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            logic [12:0] e, o;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {msg_ack, an, sseg};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL midrst_frame c=%0d: got %h want %h", c, o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_freq;
        test_current;
`ifdef DISP_MSG_EN
        test_msg;
        test_back_to_back;
`else
        test_no_msg;
`endif
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
